// File: rtl/br_demux_weighted_rr.sv
// Weighted round-robin 1->N distributor with a single registered slot per output.
// Latency: an accepted beat appears on pop_valid/pop_data of the chosen output the next cycle.
// Backpressure: push_ready is combinational from pop_ready; low when no weighted output has space.
module br_demux_weighted_rr #(
    parameter int NumOutputs           = 2,
    parameter int Width                = 1,
    parameter int MaxWeight            = 1,
    parameter int MaxAccumulatedWeight = MaxWeight,
    localparam int WeightWidth         = $clog2(MaxWeight + 1)
) (
    input  logic                              clk,
    input  logic                              rst,
    output logic                              push_ready,
    input  logic                              push_valid,
    input  logic [Width-1:0]                  push_data,
    input  logic [NumOutputs*WeightWidth-1:0] output_weight,
    input  logic [NumOutputs-1:0]             pop_ready,
    output logic [NumOutputs-1:0]             pop_valid,
    output logic [NumOutputs*Width-1:0]       pop_data
);
    localparam int AccWidth = $clog2(MaxAccumulatedWeight + 1);
    localparam int SumWidth = AccWidth + 1;
    localparam int IdxWidth = $clog2(NumOutputs);
    localparam logic [SumWidth-1:0] AccMax = SumWidth'(MaxAccumulatedWeight);

    if (NumOutputs < 2) begin : g_bad_num_outputs
        $error("NumOutputs must be >= 2");
    end
    if (Width < 1) begin : g_bad_width
        $error("Width must be >= 1");
    end
    if (MaxWeight < 1) begin : g_bad_max_weight
        $error("MaxWeight must be >= 1");
    end
    if (MaxAccumulatedWeight < MaxWeight) begin : g_bad_max_acc
        $error("MaxAccumulatedWeight must be >= MaxWeight");
    end

    logic [NumOutputs-1:0][WeightWidth-1:0] weight;
    logic [NumOutputs-1:0]                  space;
    logic [NumOutputs-1:0]                  eligible;
    logic [NumOutputs-1:0]                  hi;
    logic [NumOutputs-1:0]                  cand;
    logic [NumOutputs-1:0]                  sel;
    logic [IdxWidth-1:0]                    sel_idx;
    logic                                   any_hi;
    logic                                   replenish;
    logic                                   handshake;

    logic [NumOutputs-1:0]                  pop_valid_q, pop_valid_d;
    logic [NumOutputs-1:0][Width-1:0]       pop_data_q, pop_data_d;
    logic [NumOutputs-1:0][AccWidth-1:0]    acc_q, acc_d;
    logic [IdxWidth-1:0]                    last_q, last_d;

    assign weight = output_weight;
    assign space  = ~pop_valid_q | pop_ready;

    always_comb begin
        eligible = '0;
        hi       = '0;
        for (int i = 0; i < NumOutputs; i++) begin
            eligible[i] = space[i] && (weight[i] != '0);
            hi[i]       = acc_q[i] != '0;
        end
    end

    // Outputs still holding credit win; only when none do is everyone topped up.
    assign any_hi     = |(eligible & hi);
    assign replenish  = !any_hi;
    assign cand       = any_hi ? (eligible & hi) : eligible;
    assign push_ready = |eligible;
    assign handshake  = push_valid && push_ready;

    always_comb begin
        logic                found;
        logic [IdxWidth-1:0] idx;
        sel     = '0;
        sel_idx = last_q;
        found   = 1'b0;
        idx     = '0;
        for (int k = 1; k <= NumOutputs; k++) begin
            idx = IdxWidth'((int'(last_q) + k) % NumOutputs);
            if (!found && cand[idx]) begin
                sel[idx] = 1'b1;
                sel_idx  = idx;
                found    = 1'b1;
            end
        end
    end

    always_comb begin
        logic [SumWidth-1:0] sum;
        pop_valid_d = pop_valid_q & ~pop_ready;
        pop_data_d  = pop_data_q;
        acc_d       = acc_q;
        last_d      = last_q;
        sum         = '0;
        if (handshake) begin
            last_d = sel_idx;
            for (int i = 0; i < NumOutputs; i++) begin
                if (sel[i]) begin
                    pop_valid_d[i] = 1'b1;
                    pop_data_d[i]  = push_data;
                end
                // Add, charge the grant, then clamp: never wraps, never exceeds the ceiling.
                sum = SumWidth'(acc_q[i]);
                if (replenish) begin
                    sum = sum + SumWidth'(weight[i]);
                end
                if (sel[i]) begin
                    sum = (sum != '0) ? (sum - SumWidth'(1)) : '0;
                end
                acc_d[i] = (sum > AccMax) ? AccMax[AccWidth-1:0] : sum[AccWidth-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pop_valid_q <= '0;
            pop_data_q  <= '0;
            acc_q       <= '0;
            last_q      <= IdxWidth'(NumOutputs - 1);
        end else begin
            pop_valid_q <= pop_valid_d;
            pop_data_q  <= pop_data_d;
            acc_q       <= acc_d;
            last_q      <= last_d;
        end
    end

    assign pop_valid = pop_valid_q;
    assign pop_data  = pop_data_q;

    a_push_stable: assert property (@(posedge clk) disable iff (rst)
        (push_valid && !push_ready) |=> (push_valid && $stable(push_data)));
    a_sel_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(sel));
    a_sel_ready: assert property (@(posedge clk) disable iff (rst) ((|sel) == push_ready));

    for (genvar g = 0; g < NumOutputs; g++) begin : g_out_chk
        a_pop_stable: assert property (@(posedge clk) disable iff (rst)
            (pop_valid_q[g] && !pop_ready[g]) |=> (pop_valid_q[g] && $stable(pop_data_q[g])));
        a_acc_bound: assert property (@(posedge clk) disable iff (rst)
            (acc_q[g] <= AccMax[AccWidth-1:0]));
    end
endmodule

// File: tb/tb_br_demux_weighted_rr.sv
// Bench for br_demux_weighted_rr: directed scenarios plus random traffic, all
// outputs compared every cycle against a credit-based reference model.
module tb_br_demux_weighted_rr;
    localparam int N  = 3;
    localparam int W  = 8;
    localparam int MW = 3;
    localparam int MA = 4;
    localparam int WW = 2;

    logic            clk           = 1'b0;
    logic            rst           = 1'b1;
    logic            push_ready;
    logic            push_valid    = 1'b0;
    logic [W-1:0]    push_data     = '0;
    logic [N*WW-1:0] output_weight = '0;
    logic [N-1:0]    pop_ready     = '0;
    logic [N-1:0]    pop_valid;
    logic [N*W-1:0]  pop_data;

    int checks   = 0;
    int failures = 0;

    br_demux_weighted_rr #(
        .NumOutputs(N), .Width(W), .MaxWeight(MW), .MaxAccumulatedWeight(MA)
    ) dut (
        .clk(clk), .rst(rst),
        .push_ready(push_ready), .push_valid(push_valid), .push_data(push_data),
        .output_weight(output_weight),
        .pop_ready(pop_ready), .pop_valid(pop_valid), .pop_data(pop_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per-output credit, slot occupancy, last winner.
    int         m_acc [N];
    bit         m_vld [N];
    logic [W-1:0] m_dat [N];
    int         m_last;
    int         sel_q [$];
    int         dut_q [$];
    int         exp_q [$];

    function automatic int wt(int i);
        return int'(output_weight[i*WW +: WW]);
    endfunction

    function automatic bit m_elig(int i);
        return (!m_vld[i] || pop_ready[i]) && (wt(i) != 0);
    endfunction

    function automatic bit m_ready();
        bit r;
        r = 1'b0;
        for (int i = 0; i < N; i++) r = r | m_elig(i);
        return r;
    endfunction

    function automatic logic [N*WW-1:0] wts(int a, int b, int c);
        logic [N*WW-1:0] r;
        r = {WW'(c), WW'(b), WW'(a)};
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_acc[i] = 0;
                m_vld[i] = 1'b0;
                m_dat[i] = '0;
            end
            m_last = N - 1;
        end else begin : model_step
            bit elig [N];
            bit credit;
            bit go;
            int sel;
            int v;
            int j;
            credit = 1'b0;
            sel    = -1;
            go     = push_valid && m_ready();
            for (int i = 0; i < N; i++) begin
                elig[i] = m_elig(i);
                if (elig[i] && m_acc[i] > 0) credit = 1'b1;
            end
            if (go) begin
                for (int k = 1; k <= N; k++) begin
                    j = (m_last + k) % N;
                    if (sel < 0 && elig[j] && (!credit || m_acc[j] > 0)) sel = j;
                end
                for (int i = 0; i < N; i++) begin
                    v = m_acc[i] + (credit ? 0 : wt(i)) - ((i == sel) ? 1 : 0);
                    if (v > MA) v = MA;
                    if (v < 0) v = 0;
                    m_acc[i] = v;
                    if (i == sel) begin
                        m_vld[i] = 1'b1;
                        m_dat[i] = push_data;
                    end else if (pop_ready[i]) begin
                        m_vld[i] = 1'b0;
                    end
                end
                m_last = sel;
                sel_q.push_back(sel);
            end else begin
                for (int i = 0; i < N; i++) if (pop_ready[i]) m_vld[i] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        check("push_ready", 32'(push_ready), 32'(m_ready()));
        for (int i = 0; i < N; i++) begin
            check($sformatf("pop_valid[%0d]", i), 32'(pop_valid[i]), 32'(m_vld[i]));
            check($sformatf("pop_data[%0d]", i), 32'(pop_data[i*W +: W]), 32'(m_dat[i]));
        end
    end

    logic         stall   = 1'b0;
    bit           hs_seen = 1'b0;
    logic [W-1:0] hs_dat  = '0;
    logic [W-1:0] dcnt    = 8'd1;

    // Advance one cycle; record which lane the DUT loaded with the accepted beat.
    task automatic tick();
        int d;
        @(negedge clk);
        stall   = push_valid && !push_ready;
        hs_seen = push_valid && push_ready;
        hs_dat  = push_data;
        @(posedge clk);
        #1;
        if (hs_seen) begin
            d = -1;
            for (int i = 0; i < N; i++)
                if (d < 0 && pop_valid[i] && pop_data[i*W +: W] == hs_dat) d = i;
            dut_q.push_back(d);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst        = 1'b1;
        push_valid = 1'b0;
        stall      = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        sel_q.delete();
        dut_q.delete();
    endtask

    task automatic run_push(input int n);
        for (int k = 0; k < n; k++) begin
            if (!stall) begin
                push_valid = 1'b1;
                push_data  = dcnt;
                dcnt       = dcnt + 8'd1;
            end
            tick();
        end
        if (!stall) push_valid = 1'b0;
    endtask

    task automatic check_seq(input string name, input int got [$], input int exp [$]);
        check({name, "_len"}, 32'(got.size()), 32'(exp.size()));
        for (int k = 0; k < exp.size() && k < got.size(); k++)
            check($sformatf("%s[%0d]", name, k), 32'(got[k]), 32'(exp[k]));
    endtask

    function automatic int count_in(input int q [$], input int v);
        int c;
        c = 0;
        foreach (q[k]) if (q[k] == v) c++;
        return c;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values, fill two slots, then async reset between edges.
        output_weight = wts(1, 1, 0);
        pop_ready     = 3'b000;
        do_reset();
        #2;
        check("p1_reset_pop_valid", 32'(pop_valid), 32'(3'b000));
        check("p1_reset_push_ready", 32'(push_ready), 32'(1));
        run_push(2);
        #2;
        check("p1_full_pop_valid", 32'(pop_valid), 32'(3'b011));
        check("p1_full_push_ready", 32'(push_ready), 32'(0));
        rst = 1'b1;
        #1;
        check("p1_async_pop_valid", 32'(pop_valid), 32'(3'b000));
        tick();

        // Weighted distribution 1:2:3 with everyone ready.
        output_weight = wts(1, 2, 3);
        pop_ready     = 3'b111;
        do_reset();
        run_push(1);
        check("p2_acc0", 32'(m_acc[0]), 32'(0));
        check("p2_acc1", 32'(m_acc[1]), 32'(2));
        check("p2_acc2", 32'(m_acc[2]), 32'(3));
        run_push(11);
        exp_q = '{0, 1, 2, 1, 2, 2, 0, 1, 2, 1, 2, 2};
        check_seq("p2_model_dest", sel_q, exp_q);
        check_seq("p2_dut_dest", dut_q, exp_q);
        check("p2_cnt0", 32'(count_in(dut_q, 0)), 32'(2));
        check("p2_cnt1", 32'(count_in(dut_q, 1)), 32'(4));
        check("p2_cnt2", 32'(count_in(dut_q, 2)), 32'(6));

        // Output 1 stalled with a full slot keeps its credit, then is served first.
        output_weight = wts(1, 2, 3);
        pop_ready     = 3'b111;
        do_reset();
        run_push(2);
        pop_ready = 3'b101;
        run_push(3);
        check("p3_acc1_held", 32'(m_acc[1]), 32'(1));
        check("p3_slot1_held", 32'(pop_valid[1]), 32'(1));
        pop_ready = 3'b111;
        run_push(1);
        exp_q = '{0, 1, 2, 2, 2, 1};
        check_seq("p3_model_dest", sel_q, exp_q);
        check_seq("p3_dut_dest", dut_q, exp_q);

        // All slots full and nobody popping, then a same-cycle pop on output 2.
        output_weight = wts(1, 2, 3);
        pop_ready     = 3'b000;
        do_reset();
        run_push(3);
        push_valid = 1'b1;
        push_data  = 8'hA5;
        #2;
        check("p4_frozen_push_ready", 32'(push_ready), 32'(0));
        tick();
        #2;
        check("p4_frozen_push_ready2", 32'(push_ready), 32'(0));
        check("p4_frozen_pop_valid", 32'(pop_valid), 32'(3'b111));
        check("p4_acc1", 32'(m_acc[1]), 32'(1));
        check("p4_acc2", 32'(m_acc[2]), 32'(2));
        pop_ready = 3'b100;
        #1;
        check("p4_pop_push_ready", 32'(push_ready), 32'(1));
        tick();
        check("p4_refill_pop_valid", 32'(pop_valid), 32'(3'b111));
        check("p4_refill_data", 32'(pop_data[2*W +: W]), 32'(8'hA5));
        push_valid = 1'b0;
        exp_q = '{0, 1, 2, 2};
        check_seq("p4_model_dest", sel_q, exp_q);

        // Zero weights disable outputs.
        output_weight = wts(0, 3, 0);
        pop_ready     = 3'b111;
        do_reset();
        run_push(6);
        exp_q = '{1, 1, 1, 1, 1, 1};
        check_seq("p5_model_dest", sel_q, exp_q);
        check("p5_cnt1", 32'(count_in(dut_q, 1)), 32'(6));
        output_weight = wts(0, 0, 0);
        push_valid    = 1'b1;
        push_data     = 8'h3C;
        for (int k = 0; k < 5; k++) begin
            #2;
            check("p5_zero_push_ready", 32'(push_ready), 32'(0));
            tick();
        end

        // Credit saturation on a stalled output, then a burst when it frees up.
        output_weight = wts(0, 1, 0);
        pop_ready     = 3'b000;
        do_reset();
        run_push(1);
        output_weight = wts(3, 3, 0);
        pop_ready     = 3'b101;
        run_push(3);
        check("p6_acc1_first", 32'(m_acc[1]), 32'(3));
        run_push(3);
        check("p6_acc1_sat", 32'(m_acc[1]), 32'(4));
        run_push(3);
        check("p6_acc1_sat2", 32'(m_acc[1]), 32'(4));
        pop_ready = 3'b111;
        run_push(5);
        exp_q = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0};
        check_seq("p6_model_dest", sel_q, exp_q);
        check_seq("p6_dut_dest", dut_q, exp_q);

        // Random traffic against the model.
        output_weight = wts(1, 2, 3);
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) do_reset();
            if ($urandom_range(0, 31) == 0)
                output_weight = wts($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            pop_ready = N'($urandom);
            if (!stall) begin
                push_valid = ($urandom_range(0, 3) != 0);
                push_data  = W'($urandom);
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
